// File: rtl/sha256_stream_ctrl.sv
// Sequencer that packs a 32-bit word stream into padded 512-bit SHA-256 blocks and drives the core.
// Latency: a block is issued on the cycle after its 16th word or its padding cycle; digest one cycle after core ready.
// Backpressure: s_ready follows core_ready in IDLE/FILL only; digest_valid_o holds until digest_ack_i.
module sha256_stream_ctrl #(
   parameter int LEN_W = 64
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [31:0]   s_data,
   input  logic          s_last,
   input  logic [2:0]    s_bytes,
   input  logic          abort,
   output logic          core_init,
   output logic          core_next,
   output logic [511:0]  core_block,
   input  logic          core_ready,
   input  logic [255:0]  core_digest,
   input  logic          core_digest_valid,
   output logic [255:0]  digest_o,
   output logic          digest_valid_o,
   input  logic          digest_ack_i,
   output logic          busy_o
);

   typedef enum logic [3:0] {
      IDLE, FILL, PAD, LENBLK, ISSUE, WAIT1, BUSY, DRAIN, DONE
   } state_t;

   state_t            state;
   logic [31:0]       blk_w [16];
   logic [4:0]        wcnt;
   logic [LEN_W-1:0]  bitlen;
   logic              first_blk;
   logic              final_blk;
   logic              len_pend;
   logic              lead80;
   logic [4:0]        pad_idx;
   logic [1:0]        pad_byte;

   logic              accept;
   logic              go_idle;
   logic [63:0]       len64;
   logic [LEN_W-1:0]  len_add;
   logic              unused_digest_valid;

   // The core's own digest-valid strobe carries no information we need beyond core_ready.
   assign unused_digest_valid = core_digest_valid;

   // Keep only the MSB-aligned valid bytes of an incoming word.
   function automatic logic [31:0] byte_mask(input logic [2:0] n);
      logic [31:0] m;
      case (n)
         3'd0:    m = 32'h0000_0000;
         3'd1:    m = 32'hFF00_0000;
         3'd2:    m = 32'hFFFF_0000;
         3'd3:    m = 32'hFFFF_FF00;
         default: m = 32'hFFFF_FFFF;
      endcase
      return m;
   endfunction

   assign s_ready = !wb_rst_i && core_ready && (state == IDLE || state == FILL);
   assign accept  = s_valid && s_ready;
   assign len64   = 64'(bitlen);
   assign len_add = LEN_W'({s_bytes, 3'b000});
   assign busy_o  = (state != IDLE);

   // Flatten the word buffer onto the core block bus, word 0 in the top bits.
   always_comb begin
      core_block = '0;
      for (int i = 0; i < 16; i++) begin
         core_block[511-32*i -: 32] = blk_w[i];
      end
   end

   // Conditions that return the controller to IDLE with everything cleared.
   always_comb begin
      go_idle = 1'b0;
      if (abort && !(state inside {ISSUE, WAIT1, BUSY, DRAIN})) begin
         go_idle = 1'b1;
      end
      if (state == DRAIN && core_ready) begin
         go_idle = 1'b1;
      end
      if (state == DONE && digest_ack_i) begin
         go_idle = 1'b1;
      end
   end

   // Main sequencer: word assembly, padding, core handshake and digest hand-off.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state          <= IDLE;
         for (int i = 0; i < 16; i++) begin
            blk_w[i] <= '0;
         end
         wcnt           <= '0;
         bitlen         <= '0;
         first_blk      <= 1'b0;
         final_blk      <= 1'b0;
         len_pend       <= 1'b0;
         lead80         <= 1'b0;
         pad_idx        <= '0;
         pad_byte       <= '0;
         core_init      <= 1'b0;
         core_next      <= 1'b0;
         digest_o       <= '0;
         digest_valid_o <= 1'b0;
      end else begin
         core_init <= 1'b0;
         core_next <= 1'b0;
         if (go_idle) begin
            state <= IDLE;
            for (int i = 0; i < 16; i++) begin
               blk_w[i] <= '0;
            end
            wcnt           <= '0;
            bitlen         <= '0;
            first_blk      <= 1'b0;
            final_blk      <= 1'b0;
            len_pend       <= 1'b0;
            lead80         <= 1'b0;
            digest_valid_o <= 1'b0;
         end else if (abort) begin
            // Core already owns a block: let it finish without latching its result.
            state <= DRAIN;
         end else begin
            case (state)
               IDLE, FILL: begin
                  if (accept) begin
                     blk_w[wcnt[3:0]] <= s_data & byte_mask(s_bytes);
                     wcnt   <= wcnt + 5'd1;
                     bitlen <= bitlen + len_add;
                     if (state == IDLE) begin
                        first_blk <= 1'b1;
                     end
                     if (s_last) begin
                        // A full last word pushes the 0x80 marker into the following word.
                        pad_idx  <= (s_bytes >= 3'd4) ? wcnt + 5'd1 : wcnt;
                        pad_byte <= (s_bytes >= 3'd4) ? 2'd0 : s_bytes[1:0];
                        state    <= PAD;
                     end else if (wcnt == 5'd15) begin
                        core_init <= (state == IDLE) || first_blk;
                        core_next <= !((state == IDLE) || first_blk);
                        state     <= ISSUE;
                     end else begin
                        state <= FILL;
                     end
                  end
               end
               PAD: begin
                  for (int i = 0; i < 16; i++) begin
                     if (5'(i) == pad_idx) begin
                        blk_w[i] <= blk_w[i] | (32'h8000_0000 >> {pad_byte, 3'b000});
                     end else if (5'(i) > pad_idx) begin
                        blk_w[i] <= '0;
                     end
                  end
                  if (pad_idx <= 5'd13) begin
                     blk_w[14] <= len64[63:32];
                     blk_w[15] <= len64[31:0];
                     final_blk <= 1'b1;
                  end else begin
                     // Length does not fit; a dedicated block follows, which also carries
                     // the 0x80 marker when this block was completely full of data.
                     len_pend <= 1'b1;
                     lead80   <= (pad_idx == 5'd16);
                  end
                  core_init <= first_blk;
                  core_next <= !first_blk;
                  state     <= ISSUE;
               end
               LENBLK: begin
                  for (int i = 0; i < 16; i++) begin
                     blk_w[i] <= '0;
                  end
                  blk_w[0]  <= lead80 ? 32'h8000_0000 : 32'h0;
                  blk_w[14] <= len64[63:32];
                  blk_w[15] <= len64[31:0];
                  final_blk <= 1'b1;
                  len_pend  <= 1'b0;
                  lead80    <= 1'b0;
                  core_init <= first_blk;
                  core_next <= !first_blk;
                  state     <= ISSUE;
               end
               ISSUE: begin
                  first_blk <= 1'b0;
                  state     <= WAIT1;
               end
               WAIT1: begin
                  state <= BUSY;
               end
               BUSY: begin
                  if (core_ready) begin
                     if (final_blk) begin
                        digest_o       <= core_digest;
                        digest_valid_o <= 1'b1;
                        state          <= DONE;
                     end else if (len_pend) begin
                        state <= LENBLK;
                     end else begin
                        for (int i = 0; i < 16; i++) begin
                           blk_w[i] <= '0;
                        end
                        wcnt  <= '0;
                        state <= FILL;
                     end
                  end
               end
               DONE, DRAIN: begin
                  state <= state;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// Bench for sha256_stream_ctrl: byte-level padding model plus a real SHA-256 core model.
// Each core pulse is checked against the model's next expected block; digests are checked end to end.
// Directed messages cover block boundaries, abort paths and a held digest acknowledge.
module tb_sha256_stream_ctrl;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [31:0]   s_data = '0;
   logic          s_last = 1'b0;
   logic [2:0]    s_bytes = '0;
   logic          abort = 1'b0;
   logic          core_init;
   logic          core_next;
   logic [511:0]  core_block;
   logic          core_ready = 1'b1;
   logic [255:0]  core_digest = '0;
   logic          core_digest_valid = 1'b0;
   logic [255:0]  digest_o;
   logic          digest_valid_o;
   logic          digest_ack_i = 1'b0;
   logic          busy_o;

   sha256_stream_ctrl #(.LEN_W(64)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_bytes(s_bytes),
      .abort(abort),
      .core_init(core_init), .core_next(core_next), .core_block(core_block),
      .core_ready(core_ready), .core_digest(core_digest), .core_digest_valid(core_digest_valid),
      .digest_o(digest_o), .digest_valid_o(digest_valid_o), .digest_ack_i(digest_ack_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam int CORE_LAT = 20;

   logic [31:0]   msg_w [32];
   logic [511:0]  exp_q [$];
   logic [511:0]  cap_q [$];
   logic [255:0]  exp_dig;
   int            pulse_idx = 0;
   bit            dv_forbid = 1'b0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      {a, b, c, d, e, f, g, h} = hin;
      for (int i = 0; i < 64; i++) begin
         s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
         t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
         s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
         t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
   endfunction

   // Byte-level model: message bytes, 0x80, zero fill to 56 mod 64, 64-bit bit length.
   task automatic build_model(input int n, input int lb);
      byte unsigned mb [$];
      logic [63:0]  blen;
      logic [511:0] blk;
      logic [255:0] h;
      for (int i = 0; i < n; i++) begin
         int nb = (i == n - 1) ? lb : 4;
         for (int b = 0; b < nb; b++) mb.push_back(msg_w[i][31-8*b -: 8]);
      end
      blen = 64'(mb.size()) * 64'd8;
      mb.push_back(8'h80);
      while (mb.size() % 64 != 56) mb.push_back(8'h00);
      for (int b = 0; b < 8; b++) mb.push_back(blen[63-8*b -: 8]);
      exp_q = {};
      cap_q = {};
      pulse_idx = 0;
      h = IV;
      for (int j = 0; j < mb.size() / 64; j++) begin
         blk = '0;
         for (int b = 0; b < 64; b++) blk = {blk[503:0], mb[64*j+b]};
         exp_q.push_back(blk);
         h = sha_compress(h, blk);
      end
      exp_dig = h;
   endtask

   // Core model and per-cycle checker, driven on the falling edge.
   logic [255:0] h_core = '0;
   int           lat_cnt = 0;
   always @(negedge clk) begin
      if (!rst) begin
         chk("init_and_next", {core_init, core_next} == 2'b11, 1'b0);
         if (digest_valid_o) chk("s_ready_in_done", s_ready, 1'b0);
         if (dv_forbid) chk("digest_valid_after_abort", digest_valid_o, 1'b0);
         core_digest_valid = 1'b0;
         if (core_init || core_next) begin
            chk("pulse_core_ready", core_ready, 1'b1);
            chk("pulse_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               chk("block", core_block, exp_q.pop_front());
               chk("init_on_first", core_init, pulse_idx == 0);
            end
            pulse_idx++;
            cap_q.push_back(core_block);
            h_core = sha_compress(core_init ? IV : h_core, core_block);
            core_ready = 1'b0;
            lat_cnt = CORE_LAT;
         end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
               core_digest = h_core;
               core_ready = 1'b1;
               core_digest_valid = 1'b1;
            end
         end
      end
   end

   task automatic send_word(input logic [31:0] d, input int nb, input logic last);
      int t = 0;
      bit done = 1'b0;
      while (!done && t < 3000) begin
         @(negedge clk);
         s_valid = 1'b1; s_data = d; s_bytes = 3'(nb); s_last = last;
         #4;
         done = s_ready;
         t++;
         @(posedge clk);
      end
      #1;
      s_valid = 1'b0; s_last = 1'b0;
      chk("send_timeout", done, 1'b1);
   endtask

   task automatic wait_dv(input string name);
      int t = 0;
      while (!digest_valid_o && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk({name, "_dv_timeout"}, t < 3000, 1'b1);
   endtask

   task automatic do_ack();
      @(negedge clk);
      digest_ack_i = 1'b1;
      @(posedge clk);
      #1 digest_ack_i = 1'b0;
      @(negedge clk);
      chk("idle_after_ack", busy_o, 1'b0);
      chk("dv_low_after_ack", digest_valid_o, 1'b0);
   endtask

   task automatic run_msg(input string name, input int n, input int lb, input bit ack);
      build_model(n, lb);
      for (int i = 0; i < n; i++) send_word(msg_w[i], (i == n - 1) ? lb : 4, i == n - 1);
      wait_dv(name);
      chk({name, "_digest"}, digest_o, exp_dig);
      chk({name, "_all_blocks"}, exp_q.size(), 0);
      if (ack) do_ack();
   endtask

   task automatic fill_words(input int n, input int seed);
      for (int i = 0; i < n; i++) msg_w[i] = 32'h9E3779B9 * (i + 1 + seed) ^ 32'h0055AA33;
   endtask

   initial begin
      logic [511:0] blk;
      int t;

      // Reset state
      #3;
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_pulses", {core_init, core_next}, 2'b00);
      chk("rst_block", core_block, '0);
      chk("rst_dv", digest_valid_o, 1'b0);
      chk("rst_digest", digest_o, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #4;
      chk("post_rst_s_ready", s_ready, 1'b1);
      chk("post_rst_busy", busy_o, 1'b0);

      // "abc"
      msg_w[0] = 32'h61626300;
      run_msg("abc", 1, 3, 1'b1);
      chk("abc_pulses", cap_q.size(), 1);
      if (cap_q.size() >= 1) begin
         chk("abc_w0", cap_q[0][511:480], 32'h61626380);
         chk("abc_w15", cap_q[0][31:0], 32'h00000018);
      end
      chk("abc_lit", digest_o,
          256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);

      // Empty message with garbage in the unused tail word
      msg_w[0] = 32'hDEADBEEF;
      run_msg("empty", 1, 0, 1'b1);
      if (cap_q.size() >= 1) chk("empty_w0", cap_q[0][511:480], 32'h80000000);
      chk("empty_lit", digest_o,
          256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);

      // 14 full words: length spills into a second block
      fill_words(14, 1);
      run_msg("w14", 14, 4, 1'b1);
      chk("w14_pulses", cap_q.size(), 2);
      if (cap_q.size() >= 2) begin
         chk("w14_b1_w14", cap_q[0][63:32], 32'h80000000);
         chk("w14_b1_w15", cap_q[0][31:0], 32'h0);
         chk("w14_b2_w0", cap_q[1][511:480], 32'h0);
         chk("w14_b2_len", cap_q[1][63:0], 64'h1C0);
      end

      // 16 full words: marker and length in a second block
      fill_words(16, 2);
      run_msg("w16", 16, 4, 1'b1);
      chk("w16_pulses", cap_q.size(), 2);
      if (cap_q.size() >= 2) begin
         chk("w16_b2_w0", cap_q[1][511:480], 32'h80000000);
         chk("w16_b2_len", cap_q[1][63:0], 64'h200);
      end

      // Boundaries: 55 bytes fits one block, 58 bytes needs two, 65 bytes crosses a data block
      fill_words(14, 3);
      run_msg("b55", 14, 3, 1'b1);
      chk("b55_pulses", cap_q.size(), 1);
      fill_words(15, 4);
      run_msg("b58", 15, 2, 1'b1);
      chk("b58_pulses", cap_q.size(), 2);
      fill_words(17, 5);
      run_msg("b65", 17, 1, 1'b1);
      chk("b65_pulses", cap_q.size(), 2);

      // Abort while filling: nothing issued, length cleared (empty hash must follow)
      fill_words(3, 6);
      exp_q = {};
      pulse_idx = 0;
      for (int i = 0; i < 3; i++) send_word(msg_w[i], 4, 1'b0);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("fill_abort_idle", busy_o, 1'b0);
      msg_w[0] = 32'h0;
      run_msg("empty2", 1, 0, 1'b1);

      // Abort during BUSY of the first block of a two-block message
      fill_words(16, 7);
      blk = '0;
      for (int i = 0; i < 16; i++) blk = {blk[479:0], msg_w[i]};
      exp_q = {blk};
      cap_q = {};
      pulse_idx = 0;
      for (int i = 0; i < 16; i++) send_word(msg_w[i], 4, 1'b0);
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("abort_blk1_issued", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      chk("abort_core_busy", core_ready, 1'b0);
      dv_forbid = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      t = 0;
      @(negedge clk);
      while (busy_o && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("abort_idle", busy_o, 1'b0);
      chk("abort_idle_after_core", core_ready, 1'b1);
      chk("abort_pulses", cap_q.size(), 1);
      repeat (3) @(negedge clk);
      dv_forbid = 1'b0;
      msg_w[0] = 32'h61626300;
      run_msg("abc_after_abort", 1, 3, 1'b1);
      chk("abc_after_abort_lit", digest_o,
          256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);

      // Hold acknowledge low with a word waiting
      msg_w[0] = 32'h61626300;
      run_msg("hold", 1, 3, 1'b0);
      s_valid = 1'b1; s_data = 32'h61626300; s_bytes = 3'd3; s_last = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #4;
         chk("hold_dv", digest_valid_o, 1'b1);
         chk("hold_s_ready", s_ready, 1'b0);
         @(negedge clk);
      end
      build_model(1, 3);
      digest_ack_i = 1'b1;
      @(posedge clk);
      #1 digest_ack_i = 1'b0;
      @(negedge clk);
      #4;
      chk("hold_idle", busy_o, 1'b0);
      chk("hold_accept_ready", s_ready, 1'b1);
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_last = 1'b0;
      wait_dv("hold2");
      chk("hold2_digest", digest_o, exp_dig);
      do_ack();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
